branch_resolver: RTL and testbench
==================================

// Module: branch_resolver
// PURPOSE
//  Sits between the ReorderBuffer commit stage and the Predictor/Fetcher. It:
//  - accepts one committed instruction per cycle;
//  - for conditional branches, sends a registered 2-bit-counter update
//    (address, taken) to the Predictor;
//  - detects mispredictions and raises a one-cycle rollback with the correct
//    next PC;
//  - blocks further commits for a drain window while the pipeline flushes;
//  - keeps saturating branch and mispredict statistics.
// PARAMETERS
//  DRAIN_CYCLES  3   cycles in DRAIN after ROLLBACK (0 = go straight to IDLE)
//  CNT_W         32  width of the statistics counters
// PORTS
//  clk_in                 in   1      clock, rising edge
//  rst_in                 in   1      reset, asynchronous, active-high
//  rdy_in                 in   1      global ready; low = freeze all state and outputs
//  commit_valid_from_rob  in   1      ROB presents a committing instruction
//  commit_is_branch       in   1      instruction is a conditional branch (OPCODE_BRANCH)
//  commit_pc              in   32     PC of the committing instruction
//  commit_pred_taken      in   1      direction the Fetcher predicted at fetch time
//  commit_taken           in   1      resolved direction
//  commit_target          in   32     resolved taken target
//  commit_ready_to_rob    out  1      commit accepted this cycle if valid&&ready
//  enable_to_predictor    out  1      one-cycle predictor update strobe
//  inst_addr_to_predictor out  32     PC for the update
//  jump_result_to_predictor out 1     resolved direction for the update
//  rollback_flag          out  1      one-cycle flush/redirect to Fetcher/RS/LSB/ROB
//  rollback_pc            out  32     redirect PC
//  branch_count           out  CNT_W  accepted branch commits, saturating
//  mispredict_count       out  CNT_W  mispredicted branch commits, saturating
// BEHAVIOUR
//  - Reset (async): state=IDLE, drain counter=0, every registered output=0.
//    commit_ready_to_rob=0 while rst_in high.
//  - commit_ready_to_rob = rdy_in && state==IDLE (combinational).
//    - accept = commit_valid_from_rob && commit_ready_to_rob.
//    - The ROB holds its entry until accepted.
//  - Accepted commit with commit_is_branch=0: no update, no count, no state change.
//  - Accepted branch at edge t (latency 1):
//    - enable_to_predictor=1 during cycle t+1; inst_addr and jump_result are
//      registered from commit_pc and commit_taken;
//    - branch_count increments.
//    - enable_to_predictor returns to 0 the next ready cycle with no new branch
//      accept; address/result hold their last values.
//  - Mispredict = commit_pred_taken != commit_taken on an accepted branch.
//    - The predictor update is still issued.
//    - mispredict_count increments.
//    - rollback_pc = commit_taken ? commit_target : commit_pc+4 (mod 2^32).
//    - state -> ROLLBACK; rollback_flag=1 for exactly cycle t+1.
//  - FSM transitions, advancing only on edges with rdy_in=1:
//    - IDLE -> ROLLBACK on mispredict accept;
//    - ROLLBACK -> DRAIN (counter loads DRAIN_CYCLES-1), or -> IDLE if
//      DRAIN_CYCLES==0;
//    - DRAIN: decrement; -> IDLE when counter==0.
//    - Ready is 0 in ROLLBACK and DRAIN.
//    - rollback_flag is cleared on leaving ROLLBACK; rollback_pc holds.
//  - rdy_in=0: no accept; FSM, counters and all outputs hold (pulses stretch;
//    consumers also gate on rdy_in).
//  - Counters saturate at 2^CNT_W-1 and never wrap.
//  - Reset mid-ROLLBACK/DRAIN: immediate return to IDLE with outputs 0; no
//    pending rollback survives.
// TESTING
//  1. Reset, then branch pc=0x100, pred=1, taken=1 -> next cycle enable=1,
//     addr=0x100, result=1, rollback=0, branch_count=1; ready stays 1.
//  2. Branch pc=0x200, pred=0, taken=1, target=0x80 -> rollback_flag=1 one
//     cycle, rollback_pc=0x80, mispredict_count=1; ready low for
//     1+DRAIN_CYCLES=4 cycles; a commit held valid is accepted on cycle 5.
//  3. Branch pc=0xFFFFFFFC, pred=1, taken=0 -> rollback_pc=0x00000000
//     (wrap); update result=0.
//  4. Back-to-back correct branches 0x10, 0x14, 0x18 over 3 cycles -> three
//     consecutive enable pulses with matching addresses; non-branch commit
//     between them -> no pulse that cycle.
//  5. Mispredict accepted, rdy_in=0 for 5 cycles -> rollback_flag held high
//     throughout, FSM frozen; rdy_in=1 -> ROLLBACK/DRAIN sequence resumes
//     unchanged.
//  6. Assert rst_in mid-DRAIN -> ready=0 during reset, all outputs 0; after
//     release ready=1 next cycle. With CNT_W=2, four correct branches ->
//     branch_count saturates at 3.

Source files
------------

// File: rtl/branch_resolver_if.sv
// Commit-side handshake plus predictor-update and rollback buses of the branch resolver.
// The slave modport is the resolver; the master modport is the ROB/consumer side.
interface branch_resolver_if;
    logic        commit_valid_from_rob;
    logic        commit_is_branch;
    logic [31:0] commit_pc;
    logic        commit_pred_taken;
    logic        commit_taken;
    logic [31:0] commit_target;
    logic        commit_ready_to_rob;
    logic        enable_to_predictor;
    logic [31:0] inst_addr_to_predictor;
    logic        jump_result_to_predictor;
    logic        rollback_flag;
    logic [31:0] rollback_pc;

    modport slave (
        input  commit_valid_from_rob, commit_is_branch, commit_pc,
               commit_pred_taken, commit_taken, commit_target,
        output commit_ready_to_rob, enable_to_predictor, inst_addr_to_predictor,
               jump_result_to_predictor, rollback_flag, rollback_pc
    );

    modport master (
        output commit_valid_from_rob, commit_is_branch, commit_pc,
               commit_pred_taken, commit_taken, commit_target,
        input  commit_ready_to_rob, enable_to_predictor, inst_addr_to_predictor,
               jump_result_to_predictor, rollback_flag, rollback_pc
    );
endinterface

// File: rtl/branch_resolver.sv
// Resolves committed conditional branches: predictor update, misprediction rollback,
// post-rollback drain window and saturating branch/mispredict statistics.
module branch_resolver #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    branch_resolver_if.slave    bus,
    output logic [CNT_W-1:0]    branch_count,
    output logic [CNT_W-1:0]    mispredict_count
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
        (DRAIN_CYCLES > 0) ? DRAIN_W'(DRAIN_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ROLLBACK = 2'd1,
        S_DRAIN    = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [31:0] redirect_pc(input logic        taken,
                                                input logic [31:0] pc,
                                                input logic [31:0] target);
        return taken ? target : pc + 32'd4;
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DRAIN_W-1:0]   r_drain_cnt;
    logic [DRAIN_W-1:0]   w_drain_nxt;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_br_accept;
    logic                 w_mispredict;

    logic                 r_enable_p1;
    logic [31:0]          r_addr_p1;
    logic                 r_result_p1;
    logic                 r_rollback_p1;
    logic [31:0]          r_rb_pc_p1;
    logic [CNT_W-1:0]     r_branch_cnt;
    logic [CNT_W-1:0]     r_mis_cnt;

    // Ready is forced low during reset even though the state already reads IDLE.
    assign w_ready      = rdy_in && !rst_in && (r_state == S_IDLE);
    assign w_accept     = bus.commit_valid_from_rob && w_ready;
    assign w_br_accept  = w_accept && bus.commit_is_branch;
    assign w_mispredict = w_br_accept && (bus.commit_pred_taken != bus.commit_taken);

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        if (rdy_in) begin
            case (r_state)
                S_IDLE: begin
                    if (w_mispredict) w_state_nxt = S_ROLLBACK;
                end
                S_ROLLBACK: begin
                    if (DRAIN_CYCLES == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DRAIN;
                        w_drain_nxt = DRAIN_LOAD;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == '0) w_state_nxt = S_IDLE;
                    else                   w_drain_nxt = r_drain_cnt - DRAIN_W'(1);
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    // Commit -> p1: predictor update, rollback and statistics, all frozen while rdy_in is low.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_enable_p1   <= 1'b0;
            r_addr_p1     <= '0;
            r_result_p1   <= 1'b0;
            r_rollback_p1 <= 1'b0;
            r_rb_pc_p1    <= '0;
            r_branch_cnt  <= '0;
            r_mis_cnt     <= '0;
        end else if (rdy_in) begin
            r_enable_p1   <= w_br_accept;
            r_rollback_p1 <= w_mispredict;
            if (w_br_accept) begin
                r_addr_p1    <= bus.commit_pc;
                r_result_p1  <= bus.commit_taken;
                r_branch_cnt <= sat_inc(r_branch_cnt);
            end
            if (w_mispredict) begin
                r_rb_pc_p1 <= redirect_pc(bus.commit_taken, bus.commit_pc, bus.commit_target);
                r_mis_cnt  <= sat_inc(r_mis_cnt);
            end
        end
    end

    assign bus.commit_ready_to_rob      = w_ready;
    assign bus.enable_to_predictor      = r_enable_p1;
    assign bus.inst_addr_to_predictor   = r_addr_p1;
    assign bus.jump_result_to_predictor = r_result_p1;
    assign bus.rollback_flag            = r_rollback_p1;
    assign bus.rollback_pc              = r_rb_pc_p1;
    assign branch_count                 = r_branch_cnt;
    assign mispredict_count             = r_mis_cnt;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with a cycle model and a predictor-update scoreboard.
module tb_branch_resolver;
    localparam int DC = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rdy = 1'b1;
    logic [CW-1:0] bc;
    logic [CW-1:0] mc;

    branch_resolver_if bus ();

    branch_resolver #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .rdy_in           (rdy),
        .bus              (bus.slave),
        .branch_count     (bc),
        .mispredict_count (mc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        res;
    } upd_t;
    upd_t sb[$];

    int checks   = 0;
    int failures = 0;

    int          m_state;
    int          m_cnt;
    logic        m_en, m_res, m_rb;
    logic [31:0] m_addr, m_rbpc;
    int          m_bc, m_mc;
    localparam int CMAX = (1 << CW) - 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0;
        m_en = 0; m_res = 0; m_rb = 0; m_addr = '0; m_rbpc = '0;
        m_bc = 0; m_mc = 0;
        sb.delete();
    endtask

    task automatic drive(input logic v, input logic br, input logic [31:0] pc,
                         input logic pred, input logic tk, input logic [31:0] tgt);
        bus.commit_valid_from_rob = v;
        bus.commit_is_branch      = br;
        bus.commit_pc             = pc;
        bus.commit_pred_taken     = pred;
        bus.commit_taken          = tk;
        bus.commit_target         = tgt;
    endtask

    task automatic cycle(input string tag);
        logic acc, br_acc, mis, rdy_edge;
        logic [31:0] pc4;
        upd_t u;
        acc      = bus.commit_valid_from_rob && rdy && !rst && (m_state == 0);
        br_acc   = acc && bus.commit_is_branch;
        mis      = br_acc && (bus.commit_pred_taken != bus.commit_taken);
        rdy_edge = rdy;
        if (br_acc) sb.push_back('{bus.commit_pc, bus.commit_taken});
        if (rdy) begin
            case (m_state)
                0: if (mis) m_state = 1;
                1: if (DC == 0) m_state = 0; else begin m_state = 2; m_cnt = DC - 1; end
                default: if (m_cnt == 0) m_state = 0; else m_cnt--;
            endcase
            m_en = br_acc;
            m_rb = mis;
            if (br_acc) begin
                m_addr = bus.commit_pc;
                m_res  = bus.commit_taken;
                if (m_bc < CMAX) m_bc++;
            end
            if (mis) begin
                pc4    = bus.commit_pc + 32'd4;
                m_rbpc = bus.commit_taken ? bus.commit_target : pc4;
                if (m_mc < CMAX) m_mc++;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".ready"}, bus.commit_ready_to_rob, rdy && (m_state == 0));
        chk({tag, ".enable"}, bus.enable_to_predictor, m_en);
        chk({tag, ".rollback"}, bus.rollback_flag, m_rb);
        chk({tag, ".rb_pc"}, bus.rollback_pc, m_rbpc);
        chk({tag, ".bcount"}, bc, m_bc);
        chk({tag, ".mcount"}, mc, m_mc);
        if (rdy_edge && bus.enable_to_predictor === 1'b1) begin
            if (sb.size() == 0) begin
                chk({tag, ".sb_underflow"}, sb.size(), 1);
            end else begin
                u = sb.pop_front();
                chk({tag, ".upd_addr"}, bus.inst_addr_to_predictor, u.addr);
                chk({tag, ".upd_res"}, bus.jump_result_to_predictor, u.res);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".ready"}, bus.commit_ready_to_rob, 0);
        chk({tag, ".enable"}, bus.enable_to_predictor, 0);
        chk({tag, ".addr"}, bus.inst_addr_to_predictor, 0);
        chk({tag, ".res"}, bus.jump_result_to_predictor, 0);
        chk({tag, ".rollback"}, bus.rollback_flag, 0);
        chk({tag, ".rb_pc"}, bus.rollback_pc, 0);
        chk({tag, ".bcount"}, bc, 0);
        chk({tag, ".mcount"}, mc, 0);
    endtask

    task automatic do_reset(input string tag);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check_zero({tag, ".async"});
        @(posedge clk);
        #1;
        check_zero({tag, ".held"});
        rst = 1'b0;
        model_reset();
        #1;
        chk({tag, ".ready_after"}, bus.commit_ready_to_rob, 1);
    endtask

    initial begin
        int n;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        do_reset("rst0");
        cycle("idle");

        // 1: correctly predicted branch
        drive(1, 1, 32'h100, 1, 1, 32'h500);
        cycle("t1");
        chk("t1.addr", bus.inst_addr_to_predictor, 32'h100);
        chk("t1.bc1", bc, 1);
        drive(0, 0, 0, 0, 0, 0);
        cycle("t1.clr");

        // 2: mispredict taken, then a commit held valid through the drain window
        drive(1, 1, 32'h200, 0, 1, 32'h80);
        cycle("t2");
        chk("t2.rbpc", bus.rollback_pc, 32'h80);
        drive(1, 0, 32'h204, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.commit_ready_to_rob === 1'b1) break;
            n++;
            cycle("t2.drain");
        end
        chk("t2.ready_low_cycles", n, 1 + DC);
        cycle("t2.accept");
        drive(0, 0, 0, 0, 0, 0);

        // 3: pc+4 wraps to zero, not-taken update
        drive(1, 1, 32'hFFFF_FFFC, 1, 0, 32'h1234);
        cycle("t3");
        chk("t3.rbpc_wrap", bus.rollback_pc, 32'h0);
        chk("t3.res0", bus.jump_result_to_predictor, 0);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DC + 1; i++) cycle("t3.drain");

        // 4: back-to-back branches with a non-branch commit in between
        drive(1, 1, 32'h10, 1, 1, 32'h40);
        cycle("t4.a");
        drive(1, 1, 32'h14, 0, 0, 32'h40);
        cycle("t4.b");
        drive(1, 0, 32'h16, 0, 0, 0);
        cycle("t4.nb");
        chk("t4.nb_noen", bus.enable_to_predictor, 0);
        drive(1, 1, 32'h18, 1, 1, 32'h40);
        cycle("t4.c");
        chk("t4.addr_c", bus.inst_addr_to_predictor, 32'h18);
        drive(0, 0, 0, 0, 0, 0);
        cycle("t4.clr");
        chk("t4.sb_empty", sb.size(), 0);

        // 5: rdy_in low freezes a pending rollback
        drive(1, 1, 32'h300, 1, 0, 32'h900);
        cycle("t5");
        drive(0, 0, 0, 0, 0, 0);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) cycle("t5.frozen");
        chk("t5.rb_held", bus.rollback_flag, 1);
        rdy = 1'b1;
        for (int i = 0; i < DC + 2; i++) cycle("t5.resume");

        // 6: reset mid-DRAIN, then counter saturation
        drive(1, 1, 32'h400, 0, 1, 32'hA00);
        cycle("t6");
        drive(0, 0, 0, 0, 0, 0);
        cycle("t6.rb");
        cycle("t6.drain");
        do_reset("rst6");
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'h1000 + 32'(4 * i), 1, 1, 32'h0);
            cycle("t6.sat");
        end
        drive(0, 0, 0, 0, 0, 0);
        cycle("t6.end");
        chk("t6.bc_sat", bc, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
